ipv4_vlg_tx_arb: RTL

Round-robin arbiter that shares the single IPv4 transmit path among N upper-layer requesters (ICMP, UDP, TCP) sitting on top of the IPv4 stack. It selects one pending frame, presents that frame's metadata to the IPv4 transmitter, and forwards the requester's payload stream to it. It enforces a fixed idle gap between frames and aborts streams that stall.

---
 rtl/ipv4_vlg_pkg.sv | 23 ++
 rtl/ipv4_vlg_tx_arb_if.sv | 43 ++++
 rtl/ipv4_vlg_rr_pick.sv | 33 +++
 rtl/ipv4_vlg_tx_arb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ipv4_vlg_pkg.sv
// ipv4_vlg_pkg: types shared by the IPv4 transmit side.
// Frame metadata, TX arbiter FSM encoding and an index-width helper.
package ipv4_vlg_pkg;

    typedef struct packed {
        logic [31:0] dst_ip;
        logic [7:0]  proto;
        logic [15:0] len;
    } ipv4_meta_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_STREAM,
        ST_GAP
    } arb_fsm_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ipv4_vlg_tx_arb_if.sv
// ipv4_vlg_tx_arb_if: requester-side and transmitter-side bundle of the
// TX arbiter. master = arbiter view, slave = requesters + IPv4 transmitter.
interface ipv4_vlg_tx_arb_if #(
    parameter int N = 3
);
    import ipv4_vlg_pkg::*;

    logic [N-1:0] req_rdy;
    ipv4_meta_t   req_meta [N];
    logic [7:0]   req_dat  [N];
    logic [N-1:0] req_val;
    logic [N-1:0] req_sof;
    logic [N-1:0] req_eof;
    logic [N-1:0] req_ack;
    logic [N-1:0] req_done;

    logic         tx_rdy;
    ipv4_meta_t   tx_meta;
    logic         tx_acc;
    logic [7:0]   tx_dat;
    logic         tx_val;
    logic         tx_sof;
    logic         tx_eof;
    logic         tx_err;
    logic         busy;

    modport master (
        input  req_rdy, req_meta, req_dat, req_val, req_sof, req_eof,
        input  tx_acc,
        output req_ack, req_done,
        output tx_rdy, tx_meta, tx_dat, tx_val, tx_sof, tx_eof, tx_err,
        output busy
    );

    modport slave (
        output req_rdy, req_meta, req_dat, req_val, req_sof, req_eof,
        output tx_acc,
        input  req_ack, req_done,
        input  tx_rdy, tx_meta, tx_dat, tx_val, tx_sof, tx_eof, tx_err,
        input  busy
    );

endinterface

// File: rtl/ipv4_vlg_rr_pick.sv
// ipv4_vlg_rr_pick: combinational round-robin picker.
// Ports: req (pending vector), ptr (start index) -> idx (winner), found.
module ipv4_vlg_rr_pick
    import ipv4_vlg_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ipv4_vlg_tx_arb.sv
// ipv4_vlg_tx_arb: round-robin share of the IPv4 TX path among N requesters.
// Ports: clk, rst (async, active high), bus (ipv4_vlg_tx_arb_if.master).
module ipv4_vlg_tx_arb
    import ipv4_vlg_pkg::*;
#(
    parameter int N   = 3,
    parameter int GAP = 2,
    parameter int TMO = 1024
) (
    input logic                clk,
    input logic                rst,
    ipv4_vlg_tx_arb_if.master  bus
);

    localparam int IW = idx_w(N);
    localparam int CW = $clog2(TMO + 1);
    localparam int GW = idx_w(GAP + 1);

    arb_fsm_t      state_q, state_d;
    logic [IW-1:0] win_q,   win_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    ipv4_meta_t    meta_q,  meta_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic [7:0]    dat_q,   dat_d;
    logic          val_q,   val_d;
    logic          sof_q,   sof_d;
    logic          eof_q,   eof_d;
    logic          err_q,   err_d;
    logic [N-1:0]  ack_q,   ack_d;
    logic [N-1:0]  done_q,  done_d;

    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [IW-1:0] win_nxt;

    ipv4_vlg_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (bus.req_rdy),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign win_nxt = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        meta_d  = meta_q;
        stall_d = stall_q;
        gap_d   = gap_q;
        dat_d   = '0;
        val_d   = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        ack_d   = '0;
        done_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    meta_d  = bus.req_meta[pick_idx];
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // A withdrawn request wins over a simultaneous accept.
                if (!bus.req_rdy[win_q]) begin
                    meta_d  = '0;
                    state_d = ST_IDLE;
                end else if (bus.tx_acc) begin
                    ack_d[win_q] = 1'b1;
                    ptr_d        = win_nxt;
                    stall_d      = '0;
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                dat_d = bus.req_dat[win_q];
                val_d = bus.req_val[win_q];
                sof_d = bus.req_sof[win_q];
                eof_d = bus.req_eof[win_q];
                if (bus.req_val[win_q]) begin
                    stall_d = '0;
                    if (bus.req_eof[win_q]) begin
                        done_d[win_q] = 1'b1;
                        gap_d         = '0;
                        state_d       = ST_GAP;
                    end
                end else if (stall_q == CW'(TMO - 1)) begin
                    // This idle cycle is the TMO-th: close the frame.
                    val_d         = 1'b0;
                    sof_d         = 1'b0;
                    eof_d         = 1'b1;
                    err_d         = 1'b1;
                    done_d[win_q] = 1'b1;
                    stall_d       = '0;
                    gap_d         = '0;
                    state_d       = ST_GAP;
                end else if (stall_q != CW'(TMO)) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP)) begin
                    gap_d   = '0;
                    meta_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            meta_q  <= '0;
            stall_q <= '0;
            gap_q   <= '0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            meta_q  <= meta_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_rdy   = (state_q == ST_OFFER);
    assign bus.tx_meta  = meta_q;
    assign bus.tx_dat   = dat_q;
    assign bus.tx_val   = val_q;
    assign bus.tx_sof   = sof_q;
    assign bus.tx_eof   = eof_q;
    assign bus.tx_err   = err_q;
    assign bus.req_ack  = ack_q;
    assign bus.req_done = done_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule
